// File: rtl/nauta_drv_gen.sv
// Registered differential stimulus generator for the Nauta transconductor inputs.
// Emits square or PRBS7 symbols on inp/inn with programmable both-low dead time.
module nauta_drv_gen #(
    parameter int         DW        = 8,
    parameter logic [6:0] LFSR_SEED = 7'h7F
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic          mode,
    input  logic [DW-1:0] half_per,
    input  logic [3:0]    dead,
    output logic          inp,
    output logic          inn,
    output logic          sym,
    output logic          sym_stb,
    output logic          active,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    typedef struct packed {
        logic          mode;
        logic [DW-1:0] hp;
        logic [3:0]    dead;
    } cfg_t;

    localparam cfg_t CFG_RST = '{mode: 1'b0, hp: DW'(1), dead: 4'd0};

    state_t        state_q, state_d;
    cfg_t          shadow_q, active_q, cfg;
    logic [6:0]    lfsr_q, lfsr_d, lfsr_step;
    logic [DW-1:0] drv_cnt_q, drv_cnt_d;
    logic [3:0]    dead_cnt_q, dead_cnt_d;
    logic          sym_d, stb_d, bnd;

    // Remaining-cycle count for a symbol; half_per of 0 behaves as 1.
    function automatic logic [DW-1:0] drive_len(input logic [DW-1:0] hp);
        return (hp == '0) ? '0 : hp - DW'(1);
    endfunction

    // Inside DEAD the latched config applies; IDLE exit and symbol boundaries take the shadow.
    assign cfg       = (state_q == DEAD) ? active_q : shadow_q;
    assign lfsr_step = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign active    = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d    = state_q;
        sym_d      = sym;
        lfsr_d     = lfsr_q;
        drv_cnt_d  = drv_cnt_q;
        dead_cnt_d = dead_cnt_q;
        stb_d      = 1'b0;
        bnd        = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    sym_d = cfg.mode ? lfsr_q[6] : 1'b1;
                    if (cfg.dead != 4'd0) begin
                        state_d    = DEAD;
                        dead_cnt_d = cfg.dead - 4'd1;
                    end else begin
                        state_d   = DRIVE;
                        drv_cnt_d = drive_len(cfg.hp);
                        stb_d     = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (dead_cnt_q == 4'd0) begin
                    state_d   = DRIVE;
                    drv_cnt_d = drive_len(cfg.hp);
                    stb_d     = 1'b1;
                end else begin
                    dead_cnt_d = dead_cnt_q - 4'd1;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (drv_cnt_q != '0) begin
                    drv_cnt_d = drv_cnt_q - DW'(1);
                end else begin
                    bnd = 1'b1;
                    if (cfg.mode) begin
                        lfsr_d = lfsr_step;
                        sym_d  = lfsr_step[6];
                    end else begin
                        sym_d = ~sym;
                    end
                    // Dead time only separates a real polarity change.
                    if ((sym_d != sym) && (cfg.dead != 4'd0)) begin
                        state_d    = DEAD;
                        dead_cnt_d = cfg.dead - 4'd1;
                    end else begin
                        state_d   = DRIVE;
                        drv_cnt_d = drive_len(cfg.hp);
                        stb_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load && (state_q == IDLE)) lfsr_d = LFSR_SEED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inp        <= 1'b0;
            inn        <= 1'b0;
            sym        <= 1'b0;
            sym_stb    <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            drv_cnt_q  <= '0;
            dead_cnt_q <= '0;
            shadow_q   <= CFG_RST;
            active_q   <= CFG_RST;
        end else begin
            state_q    <= state_d;
            sym        <= sym_d;
            sym_stb    <= stb_d;
            lfsr_q     <= lfsr_d;
            drv_cnt_q  <= drv_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            // Decoded from the next state so inp/inn can never overlap.
            inp        <= (state_d == DRIVE) && sym_d;
            inn        <= (state_d == DRIVE) && !sym_d;
            if (load) shadow_q <= '{mode: mode, hp: half_per, dead: dead};
            if ((state_q == IDLE) || bnd) active_q <= shadow_q;
        end
    end

endmodule

// File: tb/tb_nauta_drv_gen.sv
// Bench for nauta_drv_gen: expected waveforms are built from per-symbol lists
// (value, length, dead gap) and compared cycle by cycle.
module tb_nauta_drv_gen;

    localparam logic [6:0] SEED = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n, en, load, mode;
    logic [7:0] half_per;
    logic [3:0] dead;
    logic       inp, inn, sym, sym_stb, active;
    logic [1:0] state_dbg;

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [3:0] exp_q[$];
    logic       obs_q[$];
    logic [6:0] m_lfsr;
    bit         sm[300];
    int         sl[300];

    nauta_drv_gen #(.DW(8), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .mode(mode),
        .half_per(half_per), .dead(dead), .inp(inp), .inn(inn), .sym(sym),
        .sym_stb(sym_stb), .active(active), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cmp_cnt++;
        assert (!((inp === 1'b1) && (inn === 1'b1))) else begin
            err_cnt++;
            $error("FAIL overlap observed inp=%b inn=%b expected not both 1", inp, inn);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] e);
        cmp_cnt++;
        assert ({inp, inn, sym_stb, active} === e) else begin
            err_cnt++;
            $error("FAIL %s observed={inp,inn,stb,act}=%b expected=%b", tag,
                   {inp, inn, sym_stb, active}, e);
        end
    endtask

    task automatic check5(input string tag);
        cmp_cnt++;
        assert ({inp, inn, sym, sym_stb, active} === 5'b0) else begin
            err_cnt++;
            $error("FAIL %s observed={inp,inn,sym,stb,act}=%b expected=00000", tag,
                   {inp, inn, sym, sym_stb, active});
        end
    endtask

    function automatic logic [6:0] lstep(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    task automatic do_load(input int m, input int hp, input int d);
        mode = m[0]; half_per = 8'(hp); dead = 4'(d);
        en = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        m_lfsr = SEED;
        check4("load_idle", 4'b0000);
    endtask

    task automatic fill(input int n, input bit m, input int hp);
        for (int k = 0; k < n; k++) begin
            sm[k] = m;
            sl[k] = (hp < 1) ? 1 : hp;
        end
    endtask

    // Expected cycles: {inp, inn, sym_stb, active}
    task automatic build(input int nsym, input int d);
        bit s, prev;
        prev = 1'b0;
        for (int k = 0; k < nsym; k++) begin
            bit need;
            if (k == 0) begin
                s    = sm[0] ? m_lfsr[6] : 1'b1;
                need = 1'b1;
            end else begin
                if (sm[k]) begin
                    m_lfsr = lstep(m_lfsr);
                    s      = m_lfsr[6];
                end else begin
                    s = ~prev;
                end
                need = (s != prev);
            end
            if (need) for (int j = 0; j < d; j++) exp_q.push_back(4'b0001);
            for (int j = 0; j < sl[k]; j++) exp_q.push_back({s, ~s, (j == 0), 1'b1});
            prev = s;
        end
    endtask

    task automatic run_q(input string tag, input int ncyc, input int load_idx);
        int n;
        logic [3:0] e;
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            en   = 1'b1;
            load = (i == load_idx);
            tick();
            e = exp_q.pop_front();
            check4($sformatf("%s_c%0d", tag, i), e);
            if (e[1]) obs_q.push_back(inp);
        end
        load = 1'b0;
        exp_q.delete();
    endtask

    task automatic drop_en(input string tag);
        en = 1'b0;
        tick();
        check4({tag, "_off"}, 4'b0000);
    endtask

    task automatic async_rst(input string tag);
        #2 rst_n = 1'b0;
        #1 check5({tag, "_now"});
        en = 1'b0;
        tick();
        check5({tag, "_hold"});
        #2 rst_n = 1'b1;
        m_lfsr = SEED;
        tick();
        check5({tag, "_rel"});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; mode = 1'b0; half_per = 8'd0; dead = 4'd0;
        m_lfsr = SEED;
        tick();
        check5("reset_a");
        tick();
        check5("reset_en_held");
        en = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check5("reset_exit");

        // Square, half_per=3, dead=2: period 10
        do_load(0, 3, 2);
        fill(4, 1'b0, 3); build(4, 2);
        run_q("sq32", -1, -1);
        drop_en("sq32");

        // PRBS7, half_per=1, dead=1: two full periods
        do_load(1, 1, 1);
        fill(254, 1'b1, 1); obs_q.delete(); build(254, 1);
        run_q("prbs", -1, -1);
        drop_en("prbs");
        for (int i = 0; i < 127; i++) begin
            cmp_cnt++;
            assert (obs_q[i] === obs_q[i + 127]) else begin
                err_cnt++;
                $error("FAIL prbs_period%0d observed=%b expected=%b", i, obs_q[i + 127], obs_q[i]);
            end
        end

        // half_per=0, dead=0: toggle every cycle
        do_load(0, 0, 0);
        fill(8, 1'b0, 0); build(8, 0);
        run_q("hp0", -1, -1);
        drop_en("hp0");

        // Randomised configurations
        for (int r = 0; r < 6; r++) begin
            int m, hp, d, n;
            m = $urandom_range(0, 1); hp = $urandom_range(0, 6);
            d = $urandom_range(0, 3); n = $urandom_range(3, 10);
            do_load(m, hp, d);
            fill(n, m[0], hp); build(n, d);
            run_q($sformatf("rnd%0d", r), -1, -1);
            drop_en("rnd");
        end

        // Shadow load mid-DRIVE: current symbol keeps 2, next ones use 5
        do_load(0, 2, 2);
        half_per = 8'd5;
        fill(3, 1'b0, 5); sl[0] = 2; build(3, 2);
        run_q("ld", -1, 3);
        drop_en("ld");

        // en dropped mid-DRIVE, then restart with dead phase and sym=1
        do_load(0, 3, 1);
        fill(2, 1'b0, 3); build(2, 1);
        run_q("abort", 3, -1);
        drop_en("abort");
        fill(2, 1'b0, 3); build(2, 1);
        run_q("restart", -1, -1);
        drop_en("restart");

        // PRBS keeps its LFSR across an en drop
        do_load(1, 2, 1);
        fill(5, 1'b1, 2); build(5, 1);
        run_q("pk1", -1, -1);
        drop_en("pk1");
        fill(6, 1'b1, 2); build(6, 1);
        run_q("pk2", -1, -1);
        drop_en("pk2");

        // Async reset mid-DEAD, then mid-DRIVE of a PRBS run
        do_load(0, 3, 2);
        fill(2, 1'b0, 3); build(2, 2);
        run_q("rdead", 1, -1);
        async_rst("rst_dead");
        do_load(1, 3, 0);
        fill(6, 1'b1, 3); build(6, 0);
        run_q("rdrv", 7, -1);
        async_rst("rst_drive");

        // Post-reset defaults (square, hp 1, dead 0); switch to PRBS at a boundary
        mode = 1'b1; half_per = 8'd1; dead = 4'd0;
        fill(8, 1'b1, 1); sm[0] = 1'b0; sm[1] = 1'b0; build(8, 0);
        run_q("modesw", -1, 1);
        drop_en("modesw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/nauta_drv_gen.md
NAUTA_DRV_GEN -- requirements
Module: nauta_drv_gen

Purpose: registered differential stimulus generator driving the inp/inn inputs of the inverter-based Nauta transconductor stage; square or PRBS7 symbols with programmable dead time.

Interface
REQ-001 SHALL have parameter DW, default 8, width of half_per.
REQ-002 SHALL have parameter LFSR_SEED, default 7'h7F, PRBS7 reset and reseed value; it SHALL be nonzero.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  run enable; 0 forces IDLE.
REQ-006 load  input  1  one-cycle strobe that latches mode/half_per/dead into shadow registers.
REQ-007 mode  input  1  0 = square (alternating symbols), 1 = PRBS7.
REQ-008 half_per  input  DW  drive cycles per symbol; 0 is treated as 1.
REQ-009 dead  input  4  both-low cycles inserted before each symbol transition.
REQ-010 inp  output  1  positive drive, registered.
REQ-011 inn  output  1  negative drive, registered.
REQ-012 sym  output  1  current symbol value.
REQ-013 sym_stb  output  1  one-cycle pulse on the first DRIVE cycle of every symbol.
REQ-014 active  output  1  1 when the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, DEAD and DRIVE, with registered outputs decoded from the next state.
REQ-016 Outputs SHALL be: IDLE inp=inn=0; DEAD inp=inn=0; DRIVE inp=sym, inn=~sym.
REQ-017 inp and inn SHALL never both be 1 in any cycle, including reset exit and abort.
REQ-018 Config SHALL use active registers loaded from the shadow registers; in IDLE active = shadow continuously; otherwise active updates from shadow only at a symbol boundary (DRIVE exit).
REQ-019 load SHALL update the shadow registers on the sampling edge in any state; load asserted in IDLE SHALL also reseed the LFSR to LFSR_SEED.
REQ-020 IDLE with en=1 at edge E0: if dead!=0 -> DEAD for dead cycles; else -> DRIVE at E0; first DRIVE cycle begins at edge E0+dead.
REQ-021 First symbol after IDLE SHALL be 1 in square mode and lfsr[6] in PRBS mode.
REQ-022 DRIVE SHALL last max(half_per,1) cycles, then compute the next symbol: square -> ~sym; PRBS -> step LFSR with x^7+x^6+1 (shift left, feedback bit0 = b6^b5) and take new lfsr[6].
REQ-023 At DRIVE exit, if next symbol != sym and dead!=0 -> DEAD; otherwise -> DRIVE directly, with no dead time inserted when there is no transition.
REQ-024 sym_stb SHALL be 1 exactly on the first cycle of each DRIVE, including back-to-back DRIVE runs.
REQ-025 en=0 sampled in DEAD or DRIVE SHALL go to IDLE on that edge (outputs 0/0 next cycle); the partial symbol is discarded and the LFSR keeps its value.
REQ-026 The LFSR SHALL advance only on PRBS symbol boundaries and SHALL never reach all-zero.
REQ-027 Dead and drive counters SHALL be DW/4-bit down-counters with no wrap; half_per=0 and half_per=2^DW-1 SHALL both be legal.
REQ-028 A mode change applied at a boundary SHALL take effect for the symbol that boundary produces.

Reset
REQ-029 While rst_n=0: state=IDLE, inp=inn=0, sym=0, sym_stb=0, active=0, lfsr=LFSR_SEED, shadow/active config = mode 0, half_per 1, dead 0.
REQ-030 Reset release SHALL require en sampled high on a later edge before any drive starts; asserting rst_n mid-symbol SHALL force inp=inn=0 immediately.

Verification
REQ-031 Square, half_per=3, dead=2, en rise -> inp=0 for 2 cycles, 1 for 3, 0 for 2, then inn=1 for 3; period 10; sym_stb every 5 cycles.
REQ-032 PRBS, seed 7F, half_per=1, dead=1 -> 127-symbol repeating sequence; repeated symbols have no dead gap; inp&inn never both 1 (assertion).
REQ-033 half_per=0, dead=0, square -> inp/inn toggle every cycle; sym_stb constantly 1.
REQ-034 load with half_per=5 mid-DRIVE (old value 2) -> current symbol still 2 cycles; the next symbol is 5 cycles.
REQ-035 en dropped mid-DRIVE -> inp=inn=0 next cycle and active=0; re-enable -> restarts with a dead phase and sym=1 (square).
REQ-036 rst_n asserted asynchronously mid-DEAD and mid-DRIVE -> all outputs 0 without waiting for a clock edge; lfsr = LFSR_SEED after release.
